// File: rtl/fifo_lfsr_reader.sv
// Read-side FIFO traffic checker: drains a FIFO holding a Galois LFSR sequence
// and compares every word against a locally regenerated copy.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing reads and comparing
// TAIL  | normal mode only: final registered word still to compare
// DONE  | results held until the next start
module fifo_lfsr_reader #(
  parameter int                DATA_W    = 16,
  parameter string             FWFT_MODE = "FALSE",
  parameter logic [DATA_W-1:0] SEED      = 'h0001,
  parameter logic [DATA_W-1:0] TAPS      = 'hB400,
  parameter int                CNT_W     = 32
) (
  input  logic              clk200,
  input  logic              nrst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              throttle,
  input  logic              empty,
  output logic              r_req,
  input  logic [DATA_W-1:0] r_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam bit FWFT = (FWFT_MODE == "TRUE");
  localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  nw_q;
  logic [CNT_W-1:0]  issued;
  logic [DATA_W-1:0] exp_q;
  logic              rvalid;

  logic              cmp_en;
  logic              mismatch;
  logic              last_issue;
  logic [CNT_W-1:0]  err_next;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  // Read request depends only on state, flags and counters, never on r_data.
  assign r_req = nrst && (state == RUN) && !empty && throttle && (issued < nw_q);

  always_comb begin
    cmp_en     = 1'b0;
    mismatch   = 1'b0;
    err_next   = err_cnt;
    last_issue = r_req && ((issued + CNT_W'(1)) == nw_q);
    if (FWFT) cmp_en = r_req;
    else      cmp_en = rvalid && ((state == RUN) || (state == TAIL));
    mismatch = cmp_en && (r_data != exp_q);
    if (mismatch && (err_cnt != '1)) err_next = err_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk200) begin
    if (!nrst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      rd_cnt        <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      exp_q         <= SEED_EFF;
      nw_q          <= '0;
      issued        <= '0;
      rvalid        <= 1'b0;
    end else begin
      rvalid <= FWFT ? 1'b0 : r_req;
      if (r_req) issued <= issued + CNT_W'(1);
      if (cmp_en) begin
        err_cnt <= err_next;
        if (mismatch && (err_cnt == '0)) begin
          first_err_idx <= rd_cnt;
          first_err_exp <= exp_q;
          first_err_got <= r_data;
        end
        rd_cnt <= rd_cnt + CNT_W'(1);
        exp_q  <= lfsr_step(exp_q);
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            rd_cnt        <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            exp_q         <= SEED_EFF;
            issued        <= '0;
            nw_q          <= num_words;
            if (num_words != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_issue) begin
            if (FWFT) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
